// File: rtl/axi_mm_perf_window_ctrl.sv
// ---------------------------------------------------------------------------
// axi_mm_perf_window_ctrl
//
// Measurement-window sequencer for the AXI-MM performance counter datapath.
// It drives enable/clear for four external event accumulators (read packets,
// read bytes, write packets, write bytes). At the end of each window it
// snapshots the accumulators and serialises the snapshot on an AXI-Stream
// master. One-shot and continuous runs, an optional external trigger, and
// sticky overflow detection (a snapshot arriving while the stream emitter is
// still busy is dropped) are supported.
//
// Optional build macro:
//   PERF_WINDOW_HEADER_EN  - each snapshot is prefixed by a header word
//                            {4'hA, zero pad, window index after increment},
//                            making snapshots 5 words instead of 4.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN    clock, asynchronous active-low reset
//   cfg_window_len               enabled cycles per window (0 acts as 1)
//   cfg_continuous               1 = restart after each capture
//   cfg_use_trigger              1 = wait for ext_trigger before first window
//   cmd_start, cmd_stop          single-cycle start / abort pulses
//   ext_trigger                  level trigger, sampled while armed
//   acc_read_packet/read_data/
//   acc_write_packet/write_data  live accumulator values from the datapath
//   win_en, win_clear            datapath count enable and synchronous clear
//   window_done                  one-cycle pulse at each capture
//   window_index                 completed-window count (wraps)
//   busy                         sequencer running or stream in progress
//   overflow                     sticky: at least one snapshot was dropped
//   M_AXIS_TDATA/TVALID/TLAST/TREADY  snapshot stream master
// ---------------------------------------------------------------------------
module axi_mm_perf_window_ctrl #(
   parameter int COUNTER_WIDTH = 32,
   parameter int WINDOW_WIDTH  = 32,
   parameter int INDEX_WIDTH   = 16
) (
   input  logic                     M_AXI_ACLK,
   input  logic                     M_AXI_ARESETN,
   input  logic [WINDOW_WIDTH-1:0]  cfg_window_len,
   input  logic                     cfg_continuous,
   input  logic                     cfg_use_trigger,
   input  logic                     cmd_start,
   input  logic                     cmd_stop,
   input  logic                     ext_trigger,
   input  logic [COUNTER_WIDTH-1:0] acc_read_packet,
   input  logic [COUNTER_WIDTH-1:0] acc_read_data,
   input  logic [COUNTER_WIDTH-1:0] acc_write_packet,
   input  logic [COUNTER_WIDTH-1:0] acc_write_data,
   output logic                     win_en,
   output logic                     win_clear,
   output logic                     window_done,
   output logic [INDEX_WIDTH-1:0]   window_index,
   output logic                     busy,
   output logic                     overflow,
   output logic [COUNTER_WIDTH-1:0] M_AXIS_TDATA,
   output logic                     M_AXIS_TVALID,
   output logic                     M_AXIS_TLAST,
   input  logic                     M_AXIS_TREADY
);

`ifdef PERF_WINDOW_HEADER_EN
   localparam int NUM_WORDS = 5;
`else
   localparam int NUM_WORDS = 4;
`endif
   localparam int PTR_WIDTH = $clog2(NUM_WORDS);
   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_RUN,
      ST_CAPTURE
   } state_t;

   typedef enum logic [1:0] {
      EM_IDLE,
      EM_SEND,
      EM_GAP
   } emit_t;

   // Window sequencer state
   state_t                   state, state_next;
   logic [WINDOW_WIDTH-1:0]  timer, timer_next;
   logic [WINDOW_WIDTH-1:0]  window_len, window_len_next;
   logic                     continuous, continuous_next;
   logic [INDEX_WIDTH-1:0]   index_q, index_next;
   logic                     overflow_q, overflow_next;
   logic                     load;

   // Stream emitter state
   emit_t                    emit_state, emit_next;
   logic [PTR_WIDTH-1:0]     ptr, ptr_next;
   logic [COUNTER_WIDTH-1:0] snap [NUM_WORDS];

`ifdef PERF_WINDOW_HEADER_EN
   logic [COUNTER_WIDTH-1:0] header_word;
   assign header_word = {4'hA, {(COUNTER_WIDTH-4-INDEX_WIDTH){1'b0}}, index_next};
`endif

   // ------------------------------------------------------------------------
   // Sequencer state register
   // ------------------------------------------------------------------------
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; the combinational blocks below use blocking (=).
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state      <= ST_IDLE;
         timer      <= '0;
         window_len <= WINDOW_WIDTH'(1);
         continuous <= 1'b0;
         index_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_next;
         timer      <= timer_next;
         window_len <= window_len_next;
         continuous <= continuous_next;
         index_q    <= index_next;
         overflow_q <= overflow_next;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer next-state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned, which would infer a latch.
      state_next      = state;
      timer_next      = timer;
      window_len_next = window_len;
      continuous_next = continuous;
      index_next      = index_q;
      overflow_next   = overflow_q;
      win_en          = 1'b0;
      win_clear       = 1'b0;
      window_done     = 1'b0;
      load            = 1'b0;

      unique case (state)
         ST_IDLE: begin
            // A simultaneous stop cancels the start.
            if (cmd_start && !cmd_stop) begin
               window_len_next = (cfg_window_len == '0) ? WINDOW_WIDTH'(1) : cfg_window_len;
               continuous_next = cfg_continuous;
               index_next      = '0;
               overflow_next   = 1'b0;
               timer_next      = '0;
               win_clear       = 1'b1;
               state_next      = cfg_use_trigger ? ST_ARMED : ST_RUN;
            end
         end

         ST_ARMED: begin
            if (cmd_stop) begin
               win_clear  = 1'b1;
               state_next = ST_IDLE;
            end else if (ext_trigger) begin
               timer_next = '0;
               state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            win_en = 1'b1;
            if (cmd_stop) begin
               win_clear  = 1'b1;
               state_next = ST_IDLE;
            end else if (timer == window_len - WINDOW_WIDTH'(1)) begin
               timer_next = '0;
               state_next = ST_CAPTURE;
            end else begin
               timer_next = timer + WINDOW_WIDTH'(1);
            end
         end

         ST_CAPTURE: begin
            // The datapath clear lands at the end of this cycle, after the
            // accumulators have been sampled.
            win_clear = 1'b1;
            if (cmd_stop) begin
               state_next = ST_IDLE;
            end else begin
               window_done = 1'b1;
               index_next  = index_q + INDEX_WIDTH'(1);
               // Any non-idle emitter phase, including the post-stream gap,
               // means this snapshot cannot be taken.
               if (emit_state == EM_IDLE) begin
                  load = 1'b1;
               end else begin
                  overflow_next = 1'b1;
               end
               timer_next = '0;
               state_next = continuous ? ST_RUN : ST_IDLE;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Emitter state register and snapshot buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         emit_state <= EM_IDLE;
         ptr        <= '0;
      end else begin
         emit_state <= emit_next;
         ptr        <= ptr_next;
      end
   end

   // NOTE: the snapshot buffer is reset (it is only a few words) so that
   // TDATA reads zero out of reset instead of X.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            snap[i] <= '0;
         end
      end else if (load) begin
`ifdef PERF_WINDOW_HEADER_EN
         snap[0] <= header_word;
         snap[1] <= acc_read_packet;
         snap[2] <= acc_read_data;
         snap[3] <= acc_write_packet;
         snap[4] <= acc_write_data;
`else
         snap[0] <= acc_read_packet;
         snap[1] <= acc_read_data;
         snap[2] <= acc_write_packet;
         snap[3] <= acc_write_data;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Emitter next-state
   // ------------------------------------------------------------------------
   always_comb begin
      emit_next = emit_state;
      ptr_next  = ptr;

      unique case (emit_state)
         EM_IDLE: begin
            if (load) begin
               ptr_next  = '0;
               emit_next = EM_SEND;
            end
         end

         EM_SEND: begin
            if (M_AXIS_TREADY) begin
               if (ptr == LAST_PTR) begin
                  emit_next = EM_GAP;
               end else begin
                  ptr_next = ptr + PTR_WIDTH'(1);
               end
            end
         end

         // One dead cycle with TVALID low between snapshots.
         EM_GAP: emit_next = EM_IDLE;

         default: emit_next = EM_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign M_AXIS_TVALID = (emit_state == EM_SEND);
   assign M_AXIS_TDATA  = snap[ptr];
   assign M_AXIS_TLAST  = (emit_state == EM_SEND) && (ptr == LAST_PTR);
   assign window_index  = index_q;
   assign overflow      = overflow_q;
   assign busy          = (state != ST_IDLE) || (emit_state != EM_IDLE);

endmodule

// File: tb/tb_axi_mm_perf_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_mm_perf_window_ctrl
//
// Self-checking bench for axi_mm_perf_window_ctrl. Expected control outputs
// are derived from the window arithmetic (window period L+1 cycles counted
// from the first enabled cycle); the stream is predicted from a queue of
// pending snapshot words. Honours PERF_WINDOW_HEADER_EN.
// ---------------------------------------------------------------------------
module tb_axi_mm_perf_window_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cfg_window_len = '0;
   logic        cfg_continuous = 1'b0;
   logic        cfg_use_trigger = 1'b0;
   logic        cmd_start = 1'b0;
   logic        cmd_stop = 1'b0;
   logic        ext_trigger = 1'b0;
   logic [31:0] acc_read_packet = '0;
   logic [31:0] acc_read_data = '0;
   logic [31:0] acc_write_packet = '0;
   logic [31:0] acc_write_data = '0;
   logic        win_en, win_clear, window_done, busy, overflow;
   logic [15:0] window_index;
   logic [31:0] tdata;
   logic        tvalid, tlast;
   logic        tready = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model state carried across scenarios
   logic [31:0] exp_q [$];
   bit          m_gap = 1'b0;
   logic [15:0] m_index = '0;
   bit          m_ovf = 1'b0;

   always #5 clk = ~clk;

   axi_mm_perf_window_ctrl dut (
      .M_AXI_ACLK       (clk),
      .M_AXI_ARESETN    (rst_n),
      .cfg_window_len   (cfg_window_len),
      .cfg_continuous   (cfg_continuous),
      .cfg_use_trigger  (cfg_use_trigger),
      .cmd_start        (cmd_start),
      .cmd_stop         (cmd_stop),
      .ext_trigger      (ext_trigger),
      .acc_read_packet  (acc_read_packet),
      .acc_read_data    (acc_read_data),
      .acc_write_packet (acc_write_packet),
      .acc_write_data   (acc_write_data),
      .win_en           (win_en),
      .win_clear        (win_clear),
      .window_done      (window_done),
      .window_index     (window_index),
      .busy             (busy),
      .overflow         (overflow),
      .M_AXIS_TDATA     (tdata),
      .M_AXIS_TVALID    (tvalid),
      .M_AXIS_TLAST     (tlast),
      .M_AXIS_TREADY    (tready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One run from a start pulse at t=0. stop_at<0 means no stop pulse;
   // stop_at==0 puts the stop on the start cycle. tready is held low until
   // ready_hold, then high with probability ready_pct percent.
   task automatic scenario(input string tag, input int len_cfg, input bit cont,
                           input bit trig, input int trig_wait, input int stop_at,
                           input int ready_hold, input int ready_pct,
                           input bit fix_acc, input int n_cycles);
      int L, run_start, k, w, p;
      bit started, armed, running, capture, ctrl_idle, stopped_now;
      bit emit_busy, exp_valid, beat, new_gap;
      L         = (len_cfg == 0) ? 1 : len_cfg;
      run_start = trig ? trig_wait + 2 : 1;
      started   = (stop_at != 0);
      for (int t = 0; t < n_cycles; t++) begin
         @(posedge clk);
         #1;
         cmd_start = (t == 0);
         cmd_stop  = (t == stop_at);
         if (t == 0) begin
            cfg_window_len  = len_cfg;
            cfg_continuous  = cont;
            cfg_use_trigger = trig;
         end else begin
            // Config changes after the start must not matter.
            cfg_window_len  = $urandom;
            cfg_continuous  = 1'($urandom);
            cfg_use_trigger = 1'($urandom);
         end
         ext_trigger = trig ? (t >= trig_wait + 1) : 1'($urandom);
         if (fix_acc) begin
            acc_read_packet  = 32'd3;
            acc_read_data    = 32'd96;
            acc_write_packet = 32'd2;
            acc_write_data   = 32'd64;
         end else begin
            acc_read_packet  = $urandom;
            acc_read_data    = $urandom;
            acc_write_packet = $urandom;
            acc_write_data   = $urandom;
         end
         tready = (t >= ready_hold) && ($urandom_range(0, 99) < ready_pct);
         #1;

         // Where the sequencer is in this cycle
         armed = 0; running = 0; capture = 0;
         if (started && t > 0 && (stop_at < 0 || t <= stop_at)) begin
            if (t < run_start) begin
               armed = 1;
            end else begin
               k = t - run_start;
               w = k / (L + 1);
               p = k % (L + 1);
               if (cont || w == 0) begin
                  running = (p < L);
                  capture = (p == L);
               end
            end
         end
         ctrl_idle   = !(armed || running || capture);
         stopped_now = (t == stop_at) && !ctrl_idle;
         if (stopped_now) capture = 0;
         emit_busy = (exp_q.size() != 0) || m_gap;
         exp_valid = (exp_q.size() != 0);

         check($sformatf("%s t=%0d win_en", tag, t), 32'(win_en), 32'(running));
         check($sformatf("%s t=%0d window_done", tag, t), 32'(window_done), 32'(capture));
         check($sformatf("%s t=%0d win_clear", tag, t), 32'(win_clear),
               32'((t == 0 && started) || capture || stopped_now));
         check($sformatf("%s t=%0d window_index", tag, t), 32'(window_index), 32'(m_index));
         check($sformatf("%s t=%0d overflow", tag, t), 32'(overflow), 32'(m_ovf));
         check($sformatf("%s t=%0d busy", tag, t), 32'(busy), 32'(!ctrl_idle || emit_busy));
         check($sformatf("%s t=%0d tvalid", tag, t), 32'(tvalid), 32'(exp_valid));
         if (exp_valid) begin
            check($sformatf("%s t=%0d tdata", tag, t), tdata, exp_q[0]);
            check($sformatf("%s t=%0d tlast", tag, t), 32'(tlast), 32'(exp_q.size() == 1));
         end

         // Model update for the coming clock edge
         beat    = exp_valid && tready;
         new_gap = beat && (exp_q.size() == 1);
         if (beat) void'(exp_q.pop_front());
         if (capture) begin
            m_index++;
            if (emit_busy) begin
               m_ovf = 1;
            end else begin
`ifdef PERF_WINDOW_HEADER_EN
               exp_q.push_back({4'hA, 12'h000, m_index});
`endif
               exp_q.push_back(acc_read_packet);
               exp_q.push_back(acc_read_data);
               exp_q.push_back(acc_write_packet);
               exp_q.push_back(acc_write_data);
            end
         end
         m_gap = new_gap;
         if (t == 0 && started) begin
            m_index = '0;
            m_ovf   = 0;
         end
      end
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
   endtask

   initial begin
      #3;
      check("reset win_en", 32'(win_en), 32'd0);
      check("reset win_clear", 32'(win_clear), 32'd0);
      check("reset window_done", 32'(window_done), 32'd0);
      check("reset window_index", 32'(window_index), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset tvalid", 32'(tvalid), 32'd0);
      check("reset tdata", tdata, 32'd0);
      check("reset tlast", 32'(tlast), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //        tag            len cont trig tw stop hold pct fix  n
      scenario("oneshot",      4,  0,   0,   0, -1,  0,  100, 1,  16);
      scenario("overflow",     2,  1,   0,   0, 40,  20, 100, 0,  60);
      scenario("trigger",      3,  0,   1,  10, -1,  0,  70,  0,  40);
      scenario("stop",         5,  0,   0,   0,  2,  0,  100, 0,  8);
      scenario("start_stop",   4,  0,   0,   0,  0,  0,  100, 0,  4);
      scenario("len0",         0,  1,   0,   0,  9,  0,  50,  0,  30);
      for (int r = 0; r < 3; r++) begin
         scenario($sformatf("rand%0d", r), $urandom_range(1, 6), 1,
                  1'($urandom_range(0, 1)), 3, 25, 0, 60, 0, 40);
      end

      // Build up overflow with a stalled stream, advance one beat, then
      // reset in the middle of the snapshot.
      scenario("pre_reset",    1,  1,   0,   0, -1,  100, 100, 0, 8);
      tready = 1'b1;
      @(posedge clk);
      #1;
      check("mid_stream tvalid", 32'(tvalid), 32'd1);
      check("mid_stream word2", tdata, exp_q[1]);
      check("mid_stream overflow", 32'(overflow), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset tvalid", 32'(tvalid), 32'd0);
      check("async_reset busy", 32'(busy), 32'd0);
      check("async_reset overflow", 32'(overflow), 32'd0);
      check("async_reset win_en", 32'(win_en), 32'd0);
      check("async_reset window_index", 32'(window_index), 32'd0);
      exp_q.delete();
      m_gap   = 0;
      m_index = '0;
      m_ovf   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         check($sformatf("post_reset %0d busy", i), 32'(busy), 32'd0);
         check($sformatf("post_reset %0d win_en", i), 32'(win_en), 32'd0);
         check($sformatf("post_reset %0d tvalid", i), 32'(tvalid), 32'd0);
      end

      scenario("oneshot2",     4,  0,   0,   0, -1,  0,  100, 1,  16);
      check("final busy", 32'(busy), 32'd0);
      check("final window_index", 32'(window_index), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
